// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline stall/bubble control with memory-wait freeze and sticky halt
module pipe_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             mem_ready,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(MAX_WAIT) + 1;
    localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_JXX = 4'h7, I_CALL = 4'h8;
    localparam logic [3:0] I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB, R_NONE = 4'hF;
    localparam logic [3:0] S_AOK = 4'h1, S_HLT = 4'h2, S_ADR = 4'h3, S_INS = 4'h4;

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALTED} state_t;

    state_t          state, state_nx;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nx;
    logic [1:0]      reason_nx;
    logic            load_use, ret_in, mispred, exc, mem_busy, m_mem_op;

    assign load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != R_NONE &&
                      (E_dstM == d_srcA || E_dstM == d_srcB);
    assign ret_in   = D_icode == I_RET || E_icode == I_RET || M_icode == I_RET;
    assign mispred  = E_icode == I_JXX && !e_cnd;
    assign exc      = m_stat != S_AOK || W_stat != S_AOK;
    assign m_mem_op = M_icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    assign mem_busy = m_mem_op && m_stat == S_AOK && !mem_ready;
    assign halted   = state == ST_HALTED;

    always_comb begin
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        E_stall     = 1'b0;
        M_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        W_bubble    = 1'b0;
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        reason_nx   = halt_reason;

        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else if (state == ST_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_stall = 1'b1;
            M_stall = 1'b1;
        end else if (mem_busy) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            F_stall  = load_use | ret_in;
            D_stall  = load_use;
            // a stalled D register must not also be bubbled
            D_bubble = (mispred | ret_in) & !load_use;
            E_bubble = mispred | load_use;
            M_bubble = exc;
        end

        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    state_nx    = ST_WAIT;
                    wait_cnt_nx = WC_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    state_nx    = ST_RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WC_W'(MAX_WAIT - 1)) begin
                    state_nx  = ST_HALTED;
                    reason_nx = 2'd3;
                end else begin
                    wait_cnt_nx = wait_cnt + WC_W'(1);
                end
            end
            default: ;
        endcase

        // writeback status overrides a same-cycle timeout
        if (state != ST_HALTED) begin
            if (W_stat == S_HLT) begin
                state_nx  = ST_HALTED;
                reason_nx = 2'd1;
            end else if (W_stat == S_ADR || W_stat == S_INS) begin
                state_nx  = ST_HALTED;
                reason_nx = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            halt_reason <= 2'd0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            halt_reason <= reason_nx;
            if (F_stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector and sequence bench for pipe_ctrl
module tb_pipe_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic e_cnd, mem_ready;
    logic F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble;
    logic halted;
    logic [1:0] halt_reason;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .mem_ready(mem_ready),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
        .halted(halted), .halt_reason(halt_reason), .stall_cnt(stall_cnt)
    );

    // {F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble}
    typedef struct {
        string      name;
        logic [3:0] d_icode, src_a, src_b, e_icode, e_dstm;
        logic       cnd;
        logic [3:0] m_icode, mstat;
        logic       ready;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] ctl();
        return {F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
        e_cnd = 1'b1; M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1; mem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs.push_back('{"idle",        4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 8'b0000_0000});
        vecs.push_back('{"lu_mrmov_a",  4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1, 1'b1, 8'b1100_0100});
        vecs.push_back('{"lu_cleared",  4'h1, 4'hF, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1, 1'b1, 8'b0000_0000});
        vecs.push_back('{"lu_popq_b",   4'h1, 4'hF, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 4'h1, 1'b1, 8'b1100_0100});
        vecs.push_back('{"lu_dst_none", 4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 8'b0000_0000});
        vecs.push_back('{"misp_ret",    4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 4'h1, 1'b1, 8'b1000_1100});
        vecs.push_back('{"jxx_taken",   4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 8'b0000_0000});
        vecs.push_back('{"ret_in_m",    4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 4'h1, 1'b1, 8'b1000_1000});
        vecs.push_back('{"ret_lu",      4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1, 1'b1, 8'b1100_0100});
        vecs.push_back('{"m_adr",       4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h3, 1'b1, 8'b0000_0010});
        vecs.push_back('{"m_adr_nobusy",4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h4, 4'h3, 1'b0, 8'b0000_0010});
        vecs.push_back('{"nomem_wait",  4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1, 1'b0, 8'b0000_0000});

        idle();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1 check("reset_ctl", 32'(ctl()), 32'b0000_1111);
            tick();
        end
        check("reset_halted", 32'(halted), 0);
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            D_icode = vecs[i].d_icode; d_srcA = vecs[i].src_a; d_srcB = vecs[i].src_b;
            E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm; e_cnd = vecs[i].cnd;
            M_icode = vecs[i].m_icode; m_stat = vecs[i].mstat; mem_ready = vecs[i].ready;
            W_stat = 4'h1;
            #1 check(vecs[i].name, 32'(ctl()), 32'(vecs[i].exp));
            tick();
        end
        check("table_no_halt", 32'(halted), 0);

        // memory wait: three frozen cycles, then release
        do_reset();
        M_icode = 4'h5; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("wait_freeze", 32'(ctl()), 32'b1111_0001);
            tick();
        end
        mem_ready = 1'b1;
        #1 check("wait_release", 32'(ctl()), 32'b0000_0000);
        tick();
        check("wait_stall_cnt", 32'(stall_cnt), 3);

        // timeout from RUN with wait counter cleared: halts after the fourth busy cycle
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 check("to_freeze", 32'(ctl()), 32'b1111_0001);
            tick();
            check("to_halted", 32'(halted), (i == 4) ? 1 : 0);
        end
        check("to_reason", 32'(halt_reason), 3);
        mem_ready = 1'b1;
        #1 check("halted_ctl", 32'(ctl()), 32'b1111_0000);
        for (int i = 0; i < 10; i++) tick();
        check("halted_sticky", 32'(halted), 1);
        check("halted_reason_kept", 32'(halt_reason), 3);
        check("stall_cnt_sat", 32'(stall_cnt), 15);
        rst = 1'b1;
        #1 check("rst_ctl", 32'(ctl()), 32'b0000_1111);
        tick();
        rst = 1'b0;
        check("rst_clears_halt", 32'(halted), 0);
        check("rst_clears_reason", 32'(halt_reason), 0);
        check("rst_clears_cnt", 32'(stall_cnt), 0);

        // exception path
        m_stat = 4'h3;
        #1 check("exc_m_bubble", 32'(ctl()), 32'b0000_0010);
        tick();
        W_stat = 4'h3;
        #1 check("exc_w_pre", 32'(halted), 0);
        tick();
        check("exc_w_halted", 32'(halted), 1);
        check("exc_w_reason", 32'(halt_reason), 2);
        do_reset();
        check("exc_rst", 32'(halted), 0);

        W_stat = 4'h2;
        tick();
        check("hlt_reason", 32'(halt_reason), 1);
        do_reset();

        // writeback exception beats a same-cycle timeout
        M_icode = 4'h8; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("prio_not_yet", 32'(halted), 0);
        W_stat = 4'h4;
        tick();
        check("prio_halted", 32'(halted), 1);
        check("prio_reason", 32'(halt_reason), 2);
        do_reset();

        // reset in the middle of a wait restarts the wait count
        M_icode = 4'hA; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("midrst_no_halt", 32'(halted), 0);
        check("midrst_reason", 32'(halt_reason), 0);
        tick();
        check("midrst_timeout", 32'(halt_reason), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
